// File: rtl/multi_clk_divider_pkg.sv
// Shared mode encodings and reset divisor helper for the multi-channel clock divider.
// Pure definitions; no timing or flow control.
package multi_clk_divider_pkg;

  typedef enum logic {
    MODE_SQUARE = 1'b0,
    MODE_PULSE  = 1'b1
  } mode_e;

  function automatic longint default_half_period(input longint clk_freq, input longint out_freq);
    return clk_freq / (2 * out_freq);
  endfunction

endpackage

// File: rtl/multi_clk_divider_channel.sv
// One divider channel: half-period counter, square/pulse output, terminal-count tick.
// Outputs registered, one edge after the causing input; no backpressure.
module div_channel
  import multi_clk_divider_pkg::*;
#(
  parameter int               CNT_W   = 26,
  parameter logic [CNT_W-1:0] RST_DIV = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic             ld,
  input  logic [CNT_W-1:0] div_val,
  output logic             clk_out,
  output logic             tick
);

  logic [CNT_W-1:0] div_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] limit;
  mode_e            mode_q;
  mode_e            mode_now;

  assign mode_now = mode_e'(mode);
  // A zero divisor runs as a divisor of one.
  assign limit    = (div_q == '0) ? CNT_W'(1) : div_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= RST_DIV;
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
      mode_q  <= MODE_SQUARE;
    end else begin
      mode_q <= mode_now;
      if (ld) begin
        div_q <= div_val;
      end
      // Event priority: disable, mode change, load, then normal counting.
      if (!en) begin
        cnt     <= '0;
        clk_out <= 1'b0;
        tick    <= 1'b0;
      end else if (mode_now != mode_q) begin
        cnt     <= '0;
        clk_out <= 1'b0;
        tick    <= 1'b0;
      end else if (ld) begin
        cnt  <= '0;
        tick <= 1'b0;
      end else if (cnt < limit - CNT_W'(1)) begin
        cnt  <= cnt + CNT_W'(1);
        tick <= 1'b0;
        if (mode_q == MODE_PULSE) begin
          clk_out <= 1'b0;
        end
      end else begin
        cnt     <= '0;
        tick    <= 1'b1;
        clk_out <= (mode_q == MODE_PULSE) ? 1'b1 : ~clk_out;
      end
    end
  end

endmodule

// File: rtl/multi_clk_divider.sv
// NUM_CH independent clock dividers sharing one divisor load port; top holds only load decode.
// Outputs registered in the channels, one edge after the causing input; no backpressure.
module multi_clk_divider
  import multi_clk_divider_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int OUT_FREQ = 1,
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 26
) (
  input  logic                      CLK_50M,
  input  logic                      nCLR,
  input  logic [NUM_CH-1:0]         EN,
  input  logic [NUM_CH-1:0]         MODE,
  input  logic                      DIV_LD,
  input  logic [$clog2(NUM_CH)-1:0] DIV_SEL,
  input  logic [CNT_W-1:0]          DIV_VAL,
  output logic [NUM_CH-1:0]         CLK_OUT,
  output logic [NUM_CH-1:0]         TICK
);

  localparam int               SEL_W   = $clog2(NUM_CH);
  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(default_half_period(CLK_FREQ, OUT_FREQ));

  logic              sel_ok;
  logic [NUM_CH-1:0] ld;

  // Out-of-range selects only exist when NUM_CH is not a power of two.
  assign sel_ok = DIV_LD && (int'(DIV_SEL) < NUM_CH);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign ld[i] = sel_ok && (DIV_SEL == SEL_W'(i));

    div_channel #(
      .CNT_W   (CNT_W),
      .RST_DIV (RST_DIV)
    ) u_ch (
      .clk     (CLK_50M),
      .rst_n   (nCLR),
      .en      (EN[i]),
      .mode    (MODE[i]),
      .ld      (ld[i]),
      .div_val (DIV_VAL),
      .clk_out (CLK_OUT[i]),
      .tick    (TICK[i])
    );
  end

endmodule

// File: tb/tb_multi_clk_divider.sv
// Bench for multi_clk_divider at CLK_FREQ=20, OUT_FREQ=1, NUM_CH=4, CNT_W=8 (reset divisor 10).
// Expected per-edge output vectors are queued with the stimulus and popped at the following negedge.
module tb_multi_clk_divider;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;

  typedef struct packed {
    logic [NUM_CH-1:0] co;
    logic [NUM_CH-1:0] tk;
  } exp_t;

  logic              CLK_50M = 1'b0;
  logic              nCLR    = 1'b1;
  logic [NUM_CH-1:0] EN      = '0;
  logic [NUM_CH-1:0] MODE    = '0;
  logic              DIV_LD  = 1'b0;
  logic [1:0]        DIV_SEL = '0;
  logic [CNT_W-1:0]  DIV_VAL = '0;
  logic [NUM_CH-1:0] CLK_OUT;
  logic [NUM_CH-1:0] TICK;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 CLK_50M = ~CLK_50M;

  multi_clk_divider #(
    .CLK_FREQ (20),
    .OUT_FREQ (1),
    .NUM_CH   (NUM_CH),
    .CNT_W    (CNT_W)
  ) dut (
    .CLK_50M (CLK_50M),
    .nCLR    (nCLR),
    .EN      (EN),
    .MODE    (MODE),
    .DIV_LD  (DIV_LD),
    .DIV_SEL (DIV_SEL),
    .DIV_VAL (DIV_VAL),
    .CLK_OUT (CLK_OUT),
    .TICK    (TICK)
  );

  function automatic void push(input logic [NUM_CH-1:0] co, input logic [NUM_CH-1:0] tk);
    exp_t e;
    e.co = co;
    e.tk = tk;
    sb.push_back(e);
  endfunction

  task automatic test_reset();
    #1 nCLR = 1'b0;
    #1;
    n_cmp++;
    if ({CLK_OUT, TICK} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_async: got co=%b tk=%b want co=0000 tk=0000", CLK_OUT, TICK);
    end
    repeat (2) @(negedge CLK_50M);
    n_cmp++;
    if ({CLK_OUT, TICK} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_held: got co=%b tk=%b want co=0000 tk=0000", CLK_OUT, TICK);
    end
  endtask

  // ch0 square at reset divisor 10: rises at edge 10, period 20.
  task automatic test_square();
    logic [NUM_CH-1:0] eco, etk;
    exp_t e;
    nCLR = 1'b1;
    EN   = 4'b0001;
    MODE = 4'b0000;
    for (int k = 1; k <= 40; k++) begin
      eco = '0;
      etk = '0;
      eco[0] = ((k / 10) % 2) == 1;
      etk[0] = (k % 10) == 0;
      push(eco, etk);
      @(posedge CLK_50M);
      @(negedge CLK_50M);
      e = sb.pop_front();
      n_cmp++;
      if ({CLK_OUT, TICK} !== {e.co, e.tk}) begin
        n_err++;
        $display("FAIL square edge %0d: got co=%b tk=%b want co=%b tk=%b", k, CLK_OUT, TICK, e.co, e.tk);
      end
    end
  endtask

  // ch1 pulse mode: divisor 3 gives one pulse in three; divisor 0 gives a steady high.
  task automatic test_pulse();
    logic [NUM_CH-1:0] eco, etk;
    exp_t e;
    for (int c = 1; c <= 23; c++) begin
      EN      = 4'b0010;
      MODE    = 4'b0010;
      DIV_LD  = (c == 2) || (c == 15);
      DIV_SEL = 2'd1;
      DIV_VAL = (c == 2) ? 8'd3 : 8'd0;
      eco = '0;
      etk = '0;
      if (c >= 3 && c <= 14) begin
        eco[1] = ((c - 2) % 3) == 0;
        etk[1] = eco[1];
      end else if (c == 15) begin
        eco[1] = 1'b1;
      end else if (c >= 16) begin
        eco[1] = 1'b1;
        etk[1] = 1'b1;
      end
      push(eco, etk);
      @(posedge CLK_50M);
      @(negedge CLK_50M);
      e = sb.pop_front();
      n_cmp++;
      if ({CLK_OUT, TICK} !== {e.co, e.tk}) begin
        n_err++;
        $display("FAIL pulse edge %0d: got co=%b tk=%b want co=%b tk=%b", c, CLK_OUT, TICK, e.co, e.tk);
      end
    end
    DIV_LD = 1'b0;
  endtask

  // ch0 load of 4 on its terminal edge (20); then a load to idle ch3 at edge 29.
  task automatic test_load_terminal();
    logic [NUM_CH-1:0] eco, etk;
    exp_t e;
    for (int c = 1; c <= 36; c++) begin
      EN      = 4'b0001;
      MODE    = 4'b0000;
      DIV_LD  = (c == 20) || (c == 29);
      DIV_SEL = (c == 20) ? 2'd0 : 2'd3;
      DIV_VAL = (c == 20) ? 8'd4 : 8'd7;
      eco = '0;
      etk = '0;
      if (c < 10) begin
        eco[0] = 1'b0;
      end else if (c < 24) begin
        eco[0] = 1'b1;
        etk[0] = (c == 10);
      end else begin
        eco[0] = (((c - 24) / 4) % 2) == 1;
        etk[0] = ((c - 24) % 4) == 0;
      end
      push(eco, etk);
      @(posedge CLK_50M);
      @(negedge CLK_50M);
      e = sb.pop_front();
      n_cmp++;
      if ({CLK_OUT, TICK} !== {e.co, e.tk}) begin
        n_err++;
        $display("FAIL load_terminal edge %0d: got co=%b tk=%b want co=%b tk=%b", c, CLK_OUT, TICK, e.co, e.tk);
      end
    end
    DIV_LD = 1'b0;
  endtask

  // ch2 square, flipped to pulse at edge 14, disabled just before its second pulse.
  task automatic test_mode_change();
    logic [NUM_CH-1:0] eco, etk;
    exp_t e;
    for (int c = 1; c <= 36; c++) begin
      EN   = (c < 34) ? 4'b0100 : 4'b0000;
      MODE = (c < 14) ? 4'b0000 : 4'b0100;
      eco = '0;
      etk = '0;
      eco[2] = (c >= 10 && c <= 13) || (c == 24);
      etk[2] = (c == 10) || (c == 24);
      push(eco, etk);
      @(posedge CLK_50M);
      @(negedge CLK_50M);
      e = sb.pop_front();
      n_cmp++;
      if ({CLK_OUT, TICK} !== {e.co, e.tk}) begin
        n_err++;
        $display("FAIL mode_change edge %0d: got co=%b tk=%b want co=%b tk=%b", c, CLK_OUT, TICK, e.co, e.tk);
      end
    end
  endtask

  // ch3 at divisor 7, reset mid-count with a load pending; divisor returns to 10.
  task automatic test_reset_mid();
    logic [NUM_CH-1:0] eco, etk;
    exp_t e;
    EN   = 4'b1000;
    MODE = 4'b0000;
    for (int c = 1; c <= 9; c++) begin
      eco = '0;
      etk = '0;
      eco[3] = (c >= 7);
      etk[3] = (c == 7);
      push(eco, etk);
      @(posedge CLK_50M);
      @(negedge CLK_50M);
      e = sb.pop_front();
      n_cmp++;
      if ({CLK_OUT, TICK} !== {e.co, e.tk}) begin
        n_err++;
        $display("FAIL reset_mid pre edge %0d: got co=%b tk=%b want co=%b tk=%b", c, CLK_OUT, TICK, e.co, e.tk);
      end
    end
    DIV_LD  = 1'b1;
    DIV_SEL = 2'd3;
    DIV_VAL = 8'd2;
    nCLR    = 1'b0;
    push('0, '0);
    #1;
    e = sb.pop_front();
    n_cmp++;
    if ({CLK_OUT, TICK} !== {e.co, e.tk}) begin
      n_err++;
      $display("FAIL reset_mid async: got co=%b tk=%b want co=%b tk=%b", CLK_OUT, TICK, e.co, e.tk);
    end
    repeat (2) @(negedge CLK_50M);
    DIV_LD = 1'b0;
    nCLR   = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      eco = '0;
      etk = '0;
      eco[3] = (c >= 10);
      etk[3] = (c == 10);
      push(eco, etk);
      @(posedge CLK_50M);
      @(negedge CLK_50M);
      e = sb.pop_front();
      n_cmp++;
      if ({CLK_OUT, TICK} !== {e.co, e.tk}) begin
        n_err++;
        $display("FAIL reset_mid post edge %0d: got co=%b tk=%b want co=%b tk=%b", c, CLK_OUT, TICK, e.co, e.tk);
      end
    end
  endtask

  initial begin
    test_reset();
    test_square();
    test_pulse();
    test_load_terminal();
    test_mode_change();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit, compared=%0d", n_cmp);
    $fatal(1);
  end

endmodule
